// File: rtl/cache_line_refill_if.sv
// Bundle between the refill engine and its neighbours: upstream miss request,
// cache line write/lookup port, and the single-word memory bus.
interface cache_line_refill_if #(
   parameter int CACHE_LINE_WIDTH = 6,
   parameter int TAG_WIDTH        = 20,
   parameter int ADDR_WIDTH       = 32
);
   logic                        start;
   logic [ADDR_WIDTH-1:0]       missAddr;
   logic [TAG_WIDTH-1:0]        victimTag;
   logic                        victimDirty;
   logic                        busy;
   logic                        done;

   logic                        lineWrite;
   logic [CACHE_LINE_WIDTH-1:0] lineWrOff;
   logic [TAG_WIDTH-1:0]        lineWrTag;
   logic                        lineWrVaild;
   logic                        lineWrDirty;
   logic [31:0]                 lineWrData;
   logic [3:0]                  lineWrByteEnable;
   logic [31:0]                 lineLkupData;

   logic [ADDR_WIDTH-1:0]       memAddr;
   logic                        memRead;
   logic                        memWrite;
   logic [31:0]                 memWrData;
   logic [31:0]                 memRdData;
   logic                        memAck;

   modport master (
      input  start, missAddr, victimTag, victimDirty, lineLkupData, memRdData, memAck,
      output busy, done, lineWrite, lineWrOff, lineWrTag, lineWrVaild, lineWrDirty,
             lineWrData, lineWrByteEnable, memAddr, memRead, memWrite, memWrData
   );

   modport slave (
      output start, missAddr, victimTag, victimDirty, lineLkupData, memRdData, memAck,
      input  busy, done, lineWrite, lineWrOff, lineWrTag, lineWrVaild, lineWrDirty,
             lineWrData, lineWrByteEnable, memAddr, memRead, memWrite, memWrData
   );
endinterface

// File: rtl/cache_line_refill.sv
// Miss engine: optional dirty writeback then line refill, one word per memAck, no idle between words.
// Build option CACHE_REFILL_CRITICAL_WORD_FIRST_EN: refill starts at the missing word and wraps.
module cache_line_refill #(
   parameter int CACHE_LINE_WIDTH = 6,
   parameter int TAG_WIDTH        = 20,
   parameter int ADDR_WIDTH       = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   cache_line_refill_if.master bus
);
   localparam int WORD_W  = CACHE_LINE_WIDTH - 2;
   localparam int INDEX_W = ADDR_WIDTH - TAG_WIDTH - CACHE_LINE_WIDTH;

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   state_t               state_q, state_d;
   logic [WORD_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]    first_q, first_d;
   logic [TAG_WIDTH-1:0] miss_tag_q, miss_tag_d;
   logic [TAG_WIDTH-1:0] victim_tag_q, victim_tag_d;
   logic [INDEX_W-1:0]   index_q, index_d;
   logic [WORD_W-1:0]    fill_word;
   logic                 last_word;

   assign last_word = &cnt_q;
   assign fill_word = first_q + cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         first_q      <= '0;
         miss_tag_q   <= '0;
         victim_tag_q <= '0;
         index_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         miss_tag_q   <= miss_tag_d;
         victim_tag_q <= victim_tag_d;
         index_q      <= index_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      miss_tag_d   = miss_tag_q;
      victim_tag_d = victim_tag_q;
      index_d      = index_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               miss_tag_d   = bus.missAddr[ADDR_WIDTH-1 -: TAG_WIDTH];
               index_d      = bus.missAddr[CACHE_LINE_WIDTH +: INDEX_W];
               victim_tag_d = bus.victimTag;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
               first_d      = bus.missAddr[CACHE_LINE_WIDTH-1:2];
`else
               first_d      = '0;
`endif
               cnt_d        = '0;
               state_d      = bus.victimDirty ? WB : FILL;
            end
         end
         WB: begin
            if (bus.memAck) begin
               cnt_d = cnt_q + 1'b1;
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (bus.memAck) begin
               cnt_d = cnt_q + 1'b1;
               if (last_word) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Requests and line-port signals are pure functions of state and counter, so they
   // hold steady across memory wait states.
   always_comb begin
      bus.busy             = (state_q != IDLE);
      bus.done             = (state_q == DONE);
      bus.lineWrite        = 1'b0;
      bus.lineWrOff        = '0;
      bus.lineWrTag        = '0;
      bus.lineWrVaild      = 1'b0;
      bus.lineWrDirty      = 1'b0;
      bus.lineWrData       = '0;
      bus.lineWrByteEnable = 4'h0;
      bus.memAddr          = '0;
      bus.memRead          = 1'b0;
      bus.memWrite         = 1'b0;
      bus.memWrData        = '0;
      case (state_q)
         WB: begin
            bus.memWrite  = 1'b1;
            bus.memAddr   = {victim_tag_q, index_q, cnt_q, 2'b00};
            bus.lineWrOff = {cnt_q, 2'b00};
            bus.memWrData = bus.lineLkupData;
         end
         FILL: begin
            bus.memRead          = 1'b1;
            bus.memAddr          = {miss_tag_q, index_q, fill_word, 2'b00};
            bus.lineWrite        = bus.memAck;
            bus.lineWrOff        = {fill_word, 2'b00};
            bus.lineWrTag        = miss_tag_q;
            bus.lineWrVaild      = last_word;
            bus.lineWrData       = bus.memRdData;
            bus.lineWrByteEnable = {4{bus.memAck}};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: line storage and memory models plus per-scenario tasks.
module tb_cache_line_refill;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   cache_line_refill_if bus ();

   cache_line_refill dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory and line storage models
   logic [31:0] line_mem [16];
   logic [19:0] line_tag;
   logic        line_vld;
   logic        preload;
   int          wait_n;
   int          wait_cnt;

   logic [31:0] rd_addr [$];
   logic [31:0] wb_addr [$];
   logic [31:0] wb_data [$];
   logic [5:0]  fl_off  [$];
   logic [31:0] fl_data [$];
   logic        fl_vld  [$];
   logic [19:0] fl_tag  [$];
   int          both_hi;
   int          stable_err;
   logic        prev_wait;
   logic [31:0] prev_addr;
   logic [5:0]  prev_off;

   assign bus.lineLkupData = line_mem[bus.lineWrOff[5:2]];
   assign bus.memRdData    = 32'hA000_0000 + {28'd0, bus.memAddr[5:2]};
   assign bus.memAck       = (bus.memRead || bus.memWrite) && (wait_cnt == wait_n);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          wait_cnt <= 0;
      else if ((bus.memRead || bus.memWrite) && !bus.memAck) wait_cnt <= wait_cnt + 1;
      else                                                 wait_cnt <= 0;
   end

   initial begin
      line_tag   = '0;
      line_vld   = 1'b0;
      both_hi    = 0;
      stable_err = 0;
      prev_wait  = 1'b0;
      prev_addr  = '0;
      prev_off   = '0;
      for (int i = 0; i < 16; i++) line_mem[i] = '0;
   end

   always @(negedge clk) begin
      if (preload) for (int i = 0; i < 16; i++) line_mem[i] <= 32'(i);
      if (bus.lineWrite) begin
         line_mem[bus.lineWrOff[5:2]] <= bus.lineWrData;
         line_tag <= bus.lineWrTag;
         line_vld <= bus.lineWrVaild;
         fl_off.push_back(bus.lineWrOff);
         fl_data.push_back(bus.lineWrData);
         fl_vld.push_back(bus.lineWrVaild);
         fl_tag.push_back(bus.lineWrTag);
      end
      if (bus.memRead && bus.memAck) rd_addr.push_back(bus.memAddr);
      if (bus.memWrite && bus.memAck) begin
         wb_addr.push_back(bus.memAddr);
         wb_data.push_back(bus.memWrData);
      end
      if (bus.memRead && bus.memWrite) both_hi <= both_hi + 1;
      if (prev_wait && (bus.memAddr !== prev_addr || bus.lineWrOff !== prev_off))
         stable_err <= stable_err + 1;
      prev_wait <= (bus.memRead || bus.memWrite) && !bus.memAck;
      prev_addr <= bus.memAddr;
      prev_off  <= bus.lineWrOff;
   end

   // Issues one miss and counts cycles after the accepting edge until done (0 = timeout).
   task automatic do_miss(input logic [31:0] addr, input logic [19:0] vtag,
                          input logic dirty, output int n_done);
      bus.missAddr    = addr;
      bus.victimTag   = vtag;
      bus.victimDirty = dirty;
      bus.start       = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_done = 0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk); #1;
         if (bus.done) begin
            n_done = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if ({bus.memRead, bus.memWrite, bus.lineWrite} !== 3'b000)
         begin errors++; $display("FAIL reset_req: got %b want 000", {bus.memRead, bus.memWrite, bus.lineWrite}); end
      checks++; if (bus.memAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.memAddr); end
      checks++; if (bus.lineWrOff !== 6'h0) begin errors++; $display("FAIL reset_off: got %h want 0", bus.lineWrOff); end
   endtask

   task automatic test_clean();
      int n_done, b, rb;
      logic [3:0] w, first;
      first = CWF ? 4'd14 : 4'd0;
      b  = fl_off.size();
      rb = rd_addr.size();
      do_miss(32'h1234_5678, 20'h0, 1'b0, n_done);
      checks++; if (n_done !== 17) begin errors++; $display("FAIL clean_done_cycle: got %0d want 17", n_done); end
      checks++; if (fl_off.size() - b !== 16) begin errors++; $display("FAIL clean_fill_count: got %0d want 16", fl_off.size() - b); end
      if (fl_off.size() - b == 16 && rd_addr.size() - rb == 16) begin
         for (int i = 0; i < 16; i++) begin
            w = first + 4'(i);
            checks++; if (rd_addr[rb+i] !== 32'h1234_5640 + {26'd0, w, 2'b00})
               begin errors++; $display("FAIL clean_addr[%0d]: got %h want %h", i, rd_addr[rb+i], 32'h1234_5640 + {26'd0, w, 2'b00}); end
            checks++; if (fl_off[b+i] !== {w, 2'b00}) begin errors++; $display("FAIL clean_off[%0d]: got %h want %h", i, fl_off[b+i], {w, 2'b00}); end
            checks++; if (fl_data[b+i] !== 32'hA000_0000 + {28'd0, w})
               begin errors++; $display("FAIL clean_data[%0d]: got %h want %h", i, fl_data[b+i], 32'hA000_0000 + {28'd0, w}); end
            checks++; if (fl_vld[b+i] !== (i == 15)) begin errors++; $display("FAIL clean_vld[%0d]: got %b want %b", i, fl_vld[b+i], i == 15); end
            checks++; if (fl_tag[b+i] !== 20'h12345) begin errors++; $display("FAIL clean_tag[%0d]: got %h want 12345", i, fl_tag[b+i]); end
         end
      end
      checks++; if (line_vld !== 1'b1) begin errors++; $display("FAIL clean_line_valid: got %b want 1", line_vld); end
      @(negedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after: got %b want 0", bus.busy); end
      checks++; if (both_hi !== 0) begin errors++; $display("FAIL clean_rd_wr_overlap: got %0d want 0", both_hi); end
   endtask

   task automatic test_dirty();
      int n_done, wb, rb;
      preload = 1'b1;
      @(negedge clk); #1;
      preload = 1'b0;
      wb = wb_addr.size();
      rb = rd_addr.size();
      do_miss(32'h5555_5640, 20'hABCDE, 1'b1, n_done);
      checks++; if (n_done !== 33) begin errors++; $display("FAIL dirty_done_cycle: got %0d want 33", n_done); end
      checks++; if (wb_addr.size() - wb !== 16) begin errors++; $display("FAIL dirty_wb_count: got %0d want 16", wb_addr.size() - wb); end
      checks++; if (rd_addr.size() - rb !== 16) begin errors++; $display("FAIL dirty_fill_count: got %0d want 16", rd_addr.size() - rb); end
      if (wb_addr.size() - wb == 16 && rd_addr.size() - rb == 16) begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (wb_addr[wb+i] !== 32'hABCD_E640 + 32'(4*i))
               begin errors++; $display("FAIL dirty_wb_addr[%0d]: got %h want %h", i, wb_addr[wb+i], 32'hABCD_E640 + 32'(4*i)); end
            checks++; if (wb_data[wb+i] !== 32'(i)) begin errors++; $display("FAIL dirty_wb_data[%0d]: got %h want %h", i, wb_data[wb+i], i); end
            checks++; if (rd_addr[rb+i] !== 32'h5555_5640 + 32'(4*i))
               begin errors++; $display("FAIL dirty_fill_addr[%0d]: got %h want %h", i, rd_addr[rb+i], 32'h5555_5640 + 32'(4*i)); end
         end
      end
      checks++; if (line_tag !== 20'h55555) begin errors++; $display("FAIL dirty_line_tag: got %h want 55555", line_tag); end
      @(negedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dirty_busy_after: got %b want 0", bus.busy); end
   endtask

   task automatic test_wait_states();
      int n_done, b, se;
      b  = fl_off.size();
      se = stable_err;
      wait_n = 3;
      do_miss(32'h0000_0080, 20'h0, 1'b0, n_done);
      wait_n = 0;
      checks++; if (n_done !== 65) begin errors++; $display("FAIL wait_done_cycle: got %0d want 65", n_done); end
      checks++; if (fl_off.size() - b !== 16) begin errors++; $display("FAIL wait_write_count: got %0d want 16", fl_off.size() - b); end
      checks++; if (stable_err !== se) begin errors++; $display("FAIL wait_addr_stable: got %0d changes want 0", stable_err - se); end
      checks++; if (line_vld !== 1'b1) begin errors++; $display("FAIL wait_line_valid: got %b want 1", line_vld); end
      @(negedge clk); #1;
   endtask

   task automatic test_order();
      int n_done, b;
      logic [3:0] w, first;
      first = CWF ? 4'd10 : 4'd0;
      b = fl_off.size();
      do_miss(32'h0000_0028, 20'h0, 1'b0, n_done);
      checks++; if (n_done !== 17) begin errors++; $display("FAIL order_done_cycle: got %0d want 17", n_done); end
      checks++; if (fl_off.size() - b !== 16) begin errors++; $display("FAIL order_count: got %0d want 16", fl_off.size() - b); end
      if (fl_off.size() - b == 16) begin
         for (int i = 0; i < 16; i++) begin
            w = first + 4'(i);
            checks++; if (fl_off[b+i] !== {w, 2'b00}) begin errors++; $display("FAIL order_off[%0d]: got %h want %h", i, fl_off[b+i], {w, 2'b00}); end
            checks++; if (fl_vld[b+i] !== (i == 15)) begin errors++; $display("FAIL order_vld[%0d]: got %b want %b", i, fl_vld[b+i], i == 15); end
         end
      end
      @(negedge clk); #1;
   endtask

   task automatic test_start_while_busy();
      int n_done, rb, wb;
      logic busy_drop;
      rb = rd_addr.size();
      wb = wb_addr.size();
      busy_drop = 1'b0;
      n_done = 0;
      bus.missAddr = 32'h0001_0000; bus.victimTag = 20'h0; bus.victimDirty = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk); #1;
         if (n == 4) begin
            bus.start = 1'b1; bus.missAddr = 32'hFFFF_FFC0;
            bus.victimDirty = 1'b1; bus.victimTag = 20'h11111;
         end
         if (n == 8) bus.start = 1'b0;
         if (bus.done) begin
            n_done = n;
            bus.start = 1'b1;
            break;
         end
         if (!bus.busy) busy_drop = 1'b1;
      end
      @(negedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_in_done: got busy %b want 0", bus.busy); end
      checks++; if (n_done !== 17) begin errors++; $display("FAIL busy_done_cycle: got %0d want 17", n_done); end
      checks++; if (busy_drop !== 1'b0) begin errors++; $display("FAIL busy_dropped: got %b want 0", busy_drop); end
      checks++; if (wb_addr.size() - wb !== 0) begin errors++; $display("FAIL busy_no_wb: got %0d want 0", wb_addr.size() - wb); end
      if (rd_addr.size() - rb == 16) begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (rd_addr[rb+i] !== 32'h0001_0000 + 32'(4*i))
               begin errors++; $display("FAIL busy_addr[%0d]: got %h want %h", i, rd_addr[rb+i], 32'h0001_0000 + 32'(4*i)); end
         end
      end else begin
         checks++; errors++;
         $display("FAIL busy_fill_count: got %0d want 16", rd_addr.size() - rb);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid_fill();
      int n_done, b;
      b = fl_off.size();
      bus.missAddr = 32'h0000_0100; bus.victimTag = 20'h0; bus.victimDirty = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int n = 0; n < 100 && fl_off.size() - b < 7; n++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.done, bus.memRead, bus.memWrite, bus.lineWrite} !== 5'b0)
         begin errors++; $display("FAIL rstmid_ctrl: got %b want 00000", {bus.busy, bus.done, bus.memRead, bus.memWrite, bus.lineWrite}); end
      checks++; if (bus.memAddr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", bus.memAddr); end
      checks++; if ({bus.lineWrOff, bus.lineWrTag, bus.lineWrByteEnable, bus.lineWrVaild} !== '0)
         begin errors++; $display("FAIL rstmid_line: got off %h tag %h be %h vld %b want 0", bus.lineWrOff, bus.lineWrTag, bus.lineWrByteEnable, bus.lineWrVaild); end
      @(negedge clk); #1;
      checks++; if (fl_off.size() - b !== 7) begin errors++; $display("FAIL rstmid_words: got %0d want 7", fl_off.size() - b); end
      checks++; if (line_vld !== 1'b0) begin errors++; $display("FAIL rstmid_line_invalid: got %b want 0", line_vld); end
      rst_n = 1'b1;
      @(negedge clk); #1;
      b = fl_off.size();
      do_miss(32'h0000_0100, 20'h0, 1'b0, n_done);
      checks++; if (n_done !== 17) begin errors++; $display("FAIL rstmid_rerun_done: got %0d want 17", n_done); end
      checks++; if (fl_off.size() - b !== 16) begin errors++; $display("FAIL rstmid_rerun_count: got %0d want 16", fl_off.size() - b); end
      checks++; if (line_vld !== 1'b1) begin errors++; $display("FAIL rstmid_rerun_valid: got %b want 1", line_vld); end
      @(negedge clk); #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      preload = 1'b0;
      wait_n = 0;
      bus.start = 1'b0;
      bus.missAddr = '0;
      bus.victimTag = '0;
      bus.victimDirty = 1'b0;
      test_reset();
      test_clean();
      test_dirty();
      test_wait_states();
      test_order();
      test_start_while_busy();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
